mfcc_frame_sequencer: RTL and testbench



---
 rtl/mfcc_seq_pkg.sv | 28 ++
 rtl/mfcc_seq_watchdog.sv | 37 +++
 rtl/mfcc_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mfcc_frame_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_seq_pkg.sv
// Shared types for the MFCC frame sequencer: state encoding and stage ordering.
package mfcc_seq_pkg;

  localparam int unsigned STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    StIdle    = 3'd0,
    StHamming = 3'd1,
    StFft     = 3'd2,
    StMel     = 3'd3,
    StDct     = 3'd4,
    StMove    = 3'd5
  } seq_state_t;

  // Pipeline order: each stage hands over to the next once its done arrives.
  function automatic seq_state_t stage_successor(seq_state_t s);
    seq_state_t nxt;
    unique case (s)
      StHamming: nxt = StFft;
      StFft:     nxt = StMel;
      StMel:     nxt = StDct;
      StDct:     nxt = StMove;
      default:   nxt = StIdle;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mfcc_seq_watchdog.sv
// Per-stage watchdog: restarts on load_i, counts while run_i, flags expiry at WDT_CYCLES.
module mfcc_seq_watchdog #(
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CntW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(WDT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count is 0 in the stage entry cycle, so expiry lands WDT_CYCLES cycles after the start.
  assign expire_o = run_i && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// Per-frame MFCC controller: Hamming -> FFT -> Mel -> DCT -> window move, one frame queued.
// Optional per-stage watchdog is compiled in with `define MFCC_SEQ_WATCHDOG_EN.
module mfcc_frame_sequencer
  import mfcc_seq_pkg::*;
#(
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned WDT_CYCLES      = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       frame_ready_i,
  output logic                       start_move_o,
  output logic                       hamming_start_o,
  output logic                       fft_start_o,
  output logic                       mel_start_o,
  output logic                       dct_start_o,
  input  logic                       hamming_done_i,
  input  logic                       fft_done_i,
  input  logic                       mel_done_i,
  input  logic                       dct_done_i,
  output logic                       busy_o,
  output logic [STAGE_W-1:0]         stage_o,
  output logic                       frame_done_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count_o,
  output logic                       overrun_o,
  output logic                       timeout_o
);

  seq_state_t                 state_q, state_d;
  logic                       pending_q, pending_d;
  logic                       overrun_q, overrun_d;
  logic [3:0]                 start_q, start_d;  // [0] hamming .. [3] dct
  logic                       start_move_q, start_move_d;
  logic                       frame_done_q, frame_done_d;
  logic                       busy_q, busy_d;
  logic [FRAME_CNT_WIDTH-1:0] count_q, count_d;
  logic                       stage_done, wdt_expire, timeout_set, overrun_set, entering;

  always_comb begin
    stage_done = 1'b0;
    unique case (state_q)
      StHamming: stage_done = hamming_done_i;
      StFft:     stage_done = fft_done_i;
      StMel:     stage_done = mel_done_i;
      StDct:     stage_done = dct_done_i;
      default:   stage_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_set = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && (frame_ready_i || pending_q)) begin
          state_d   = StHamming;
          // A fresh request coinciding with a queued one stays queued.
          pending_d = frame_ready_i & pending_q;
        end else if (frame_ready_i) begin
          pending_d   = 1'b1;
          overrun_set = pending_q;
        end
      end
      StHamming, StFft, StMel, StDct: begin
        // Done is ignored while the stage's own start pulse is still out.
        if (stage_done && !(|start_q)) begin
          state_d = stage_successor(state_q);
        end else if (wdt_expire) begin
          state_d     = StMove;
          timeout_set = 1'b1;
        end
      end
      StMove:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (frame_ready_i && (state_q != StIdle)) begin
      pending_d   = 1'b1;
      overrun_set = pending_q;
    end
  end

  always_comb begin
    entering     = (state_d != state_q);
    start_d      = '0;
    start_d[0]   = entering && (state_d == StHamming);
    start_d[1]   = entering && (state_d == StFft);
    start_d[2]   = entering && (state_d == StMel);
    start_d[3]   = entering && (state_d == StDct);
    start_move_d = entering && (state_d == StMove);
    frame_done_d = start_move_d && !timeout_set;
    count_d      = frame_done_d ? count_q + 1'b1 : count_q;
    busy_d       = (state_d != StIdle);
    overrun_d    = overrun_set | (overrun_q & ~clear_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      start_q      <= '0;
      start_move_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      start_q      <= start_d;
      start_move_q <= start_move_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

`ifdef MFCC_SEQ_WATCHDOG_EN
  logic timeout_q, timeout_d, in_stage;

  assign in_stage  = state_q inside {StHamming, StFft, StMel, StDct};
  assign timeout_d = timeout_set | (timeout_q & ~clear_i);

  mfcc_seq_watchdog #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (entering),
    .run_i   (in_stage),
    .expire_o(wdt_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = ^WDT_CYCLES;
  assign wdt_expire     = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  assign stage_o         = state_q;
  assign busy_o          = busy_q;
  assign hamming_start_o = start_q[0];
  assign fft_start_o     = start_q[1];
  assign mel_start_o     = start_q[2];
  assign dct_start_o     = start_q[3];
  assign start_move_o    = start_move_q;
  assign frame_done_o    = frame_done_q;
  assign frame_count_o   = count_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Scoreboard bench for mfcc_frame_sequencer: frame-level reference plans feed an event queue.
module tb_mfcc_frame_sequencer;

  localparam int CW   = 2;
  localparam int WDT  = 16;
  localparam int MAXC = 2048;

  typedef struct {
    int kind;  // 1 hamming, 2 fft, 3 mel, 4 dct, 5 move
    int cyc;
    int cnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i, clear_i, frame_ready_i;
  logic          hamming_done_i, fft_done_i, mel_done_i, dct_done_i;
  logic          start_move_o, hamming_start_o, fft_start_o, mel_start_o, dct_start_o;
  logic          busy_o, frame_done_o, overrun_o, timeout_o;
  logic [2:0]    stage_o;
  logic [CW-1:0] frame_count_o;

  always #5 clk = ~clk;

  mfcc_frame_sequencer #(
    .FRAME_CNT_WIDTH(CW),
    .WDT_CYCLES     (WDT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .frame_ready_i  (frame_ready_i),
    .start_move_o   (start_move_o),
    .hamming_start_o(hamming_start_o),
    .fft_start_o    (fft_start_o),
    .mel_start_o    (mel_start_o),
    .dct_start_o    (dct_start_o),
    .hamming_done_i (hamming_done_i),
    .fft_done_i     (fft_done_i),
    .mel_done_i     (mel_done_i),
    .dct_done_i     (dct_done_i),
    .busy_o         (busy_o),
    .stage_o        (stage_o),
    .frame_done_o   (frame_done_o),
    .frame_count_o  (frame_count_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            plan_base = 0;
  int            plan_len = 0;
  bit            mon_en = 1'b1;
  bit            plan_active = 1'b0;
  bit            exp_ov = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  ev_t           sb[$];
  int            rq[$];
  int            lq[$];
  bit            fr[MAXC], hd[MAXC], fd[MAXC], md[MAXC], dd[MAXC];
  int            st[MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: requests are served one at a time, one may wait, extras are lost.
  task automatic build_plan(input bit init_pend, input int noise);
    int  a, hs, fs, ms, ds, mv, last, k;
    int  d[4];
    bit  pend, found;
    for (int c = 0; c < MAXC; c++) begin
      fr[c] = 0; hd[c] = 0; fd[c] = 0; md[c] = 0; dd[c] = 0; st[c] = 0;
    end
    last = 0;
    foreach (rq[i]) begin
      fr[rq[i]] = 1;
      if (rq[i] > last) last = rq[i];
    end
    pend     = init_pend;
    a        = 0;
    hs       = 0;
    plan_len = last + 1;
    while (1) begin
      if (!pend) begin
        found = 0;
        for (int c = hs; c <= last; c++) begin
          if (fr[c] && !found) begin
            a = c;
            found = 1;
          end
        end
        if (!found) break;
      end
      pend = pend && fr[a];
      for (int i = 0; i < 4; i++) d[i] = (lq.size() > 0) ? lq.pop_front() : $urandom_range(2, 12);
      hs = a + 1; fs = hs + d[0]; ms = fs + d[1]; ds = ms + d[2]; mv = ds + d[3];
      hd[fs-1] = 1; fd[ms-1] = 1; md[ds-1] = 1; dd[mv-1] = 1;
      if (noise > 0) begin
        hd[hs] = 1; fd[fs] = 1; md[ms] = 1; dd[ds] = 1;
      end
      for (int c = hs; c < fs; c++) st[c] = 1;
      for (int c = fs; c < ms; c++) st[c] = 2;
      for (int c = ms; c < ds; c++) st[c] = 3;
      for (int c = ds; c < mv; c++) st[c] = 4;
      st[mv] = 5;
      for (int c = a + 1; c <= mv; c++) begin
        if (fr[c]) begin
          if (pend) exp_ov = 1;
          pend = 1;
        end
      end
      exp_cnt = exp_cnt + 1'b1;
      sb.push_back('{1, plan_base + hs, 0});
      sb.push_back('{2, plan_base + fs, 0});
      sb.push_back('{3, plan_base + ms, 0});
      sb.push_back('{4, plan_base + ds, 0});
      sb.push_back('{5, plan_base + mv, int'(exp_cnt)});
      if (mv + 2 > plan_len) plan_len = mv + 2;
      hs = mv + 1;
      a  = hs;
    end
    plan_len = plan_len + 2;
    for (int c = 0; c < plan_len; c++) begin
      if ($urandom_range(1, 100) <= noise) begin
        k = $urandom_range(1, 4);
        if (st[c] != k) begin
          case (k)
            1: hd[c] = 1;
            2: fd[c] = 1;
            3: md[c] = 1;
            default: dd[c] = 1;
          endcase
        end
      end
    end
  endtask

  task automatic run_plan(input bit init_pend, input int noise);
    plan_base = cyc;
    build_plan(init_pend, noise);
    enable_i    = 1'b1;
    plan_active = 1'b1;
    for (int c = 0; c < plan_len; c++) begin
      frame_ready_i  = fr[c];
      hamming_done_i = hd[c];
      fft_done_i     = fd[c];
      mel_done_i     = md[c];
      dct_done_i     = dd[c];
      step(1);
    end
    plan_active    = 1'b0;
    frame_ready_i  = 1'b0;
    hamming_done_i = 1'b0;
    fft_done_i     = 1'b0;
    mel_done_i     = 1'b0;
    dct_done_i     = 1'b0;
    check("events_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  task automatic drive_to_mel();
    frame_ready_i = 1'b1; step(1); frame_ready_i = 1'b0;
    step(1); hamming_done_i = 1'b1; step(1); hamming_done_i = 1'b0;
    step(1); fft_done_i = 1'b1; step(1); fft_done_i = 1'b0;
  endtask

  logic [4:0] mon_p;
  ev_t        mon_ev;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      mon_p = {start_move_o, dct_start_o, mel_start_o, fft_start_o, hamming_start_o};
      check("frame_done_alone", int'(frame_done_o & ~start_move_o), 0);
      for (int k = 0; k < 5; k++) begin
        if (mon_p[k]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", k + 1, cyc);
          end else begin
            mon_ev = sb.pop_front();
            check("pulse_kind", k + 1, mon_ev.kind);
            check("pulse_cycle", cyc, mon_ev.cyc);
            if (k == 4) begin
              check("frame_done_with_move", int'(frame_done_o), 1);
              check("frame_count", int'(frame_count_o), mon_ev.cnt);
            end
          end
        end
      end
      if (plan_active && (cyc - plan_base) < plan_len) begin
        check("stage", int'(stage_o), st[cyc - plan_base]);
        check("busy", int'(busy_o), int'(st[cyc - plan_base] != 0));
      end
    end
  end

  initial begin
    int n, ms, mv_at;
    bit seen, fd_at, to_at;
    rst_n = 1'b1;
    enable_i = 1'b0; clear_i = 1'b0; frame_ready_i = 1'b0;
    hamming_done_i = 1'b0; fft_done_i = 1'b0; mel_done_i = 1'b0; dct_done_i = 1'b0;
    #2 rst_n = 1'b0;
    step(2);
    check("reset_outputs", int'({start_move_o, hamming_start_o, fft_start_o, mel_start_o,
          dct_start_o, busy_o, frame_done_o, overrun_o, timeout_o, stage_o, frame_count_o}), 0);
    rst_n = 1'b1;
    step(1);

    // Single frame with 10-cycle stages: starts at 1, 11, 21, 31, move at 41.
    rq.delete(); lq.delete(); rq.push_back(0);
    for (int i = 0; i < 4; i++) lq.push_back(10);
    run_plan(1'b0, 0);
    check("count_after_single", int'(frame_count_o), 1);

    // Two requests during FFT: one queued, one lost.
    rq.delete(); lq.delete();
    rq.push_back(0); rq.push_back(7); rq.push_back(8);
    for (int i = 0; i < 8; i++) lq.push_back(5);
    run_plan(1'b0, 0);
    check("overrun_set", int'(overrun_o), 1);
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    exp_ov = 1'b0;
    check("overrun_cleared", int'(overrun_o), 0);

    // Stray and early done pulses must not move the state.
    rq.delete(); lq.delete(); rq.push_back(0);
    for (int i = 0; i < 4; i++) lq.push_back(6);
    run_plan(1'b0, 30);

    // Disabled: the request is held as pending and served once enable rises.
    enable_i = 1'b0;
    frame_ready_i = 1'b1; step(1); frame_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("disabled_stage", int'(stage_o), 0);
      check("disabled_busy", int'(busy_o), 0);
      step(1);
    end
    rq.delete(); lq.delete();
    run_plan(1'b1, 0);

    for (int p = 0; p < 6; p++) begin
      rq.delete(); lq.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) rq.push_back($urandom_range(0, 200));
      run_plan(1'b0, 10);
    end
    check("overrun_random", int'(overrun_o), int'(exp_ov));
    check("timeout_idle", int'(timeout_o), 0);
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    exp_ov = 1'b0;

    // Reset while in MEL.
    mon_en = 1'b0;
    drive_to_mel();
    check("stage_before_reset", int'(stage_o), 3);
    step(2);
    rst_n = 1'b0;
    #1;
    check("outputs_in_reset", int'({start_move_o, hamming_start_o, fft_start_o, mel_start_o,
          dct_start_o, busy_o, frame_done_o, overrun_o, timeout_o, stage_o}), 0);
    check("count_in_reset", int'(frame_count_o), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    exp_cnt = '0;
    exp_ov  = 1'b0;
    mon_en  = 1'b1;

    // Four frames after reset: counts 1, 2, 3, 0.
    rq.delete(); lq.delete();
    for (int i = 0; i < 4; i++) rq.push_back(i * 60);
    for (int i = 0; i < 16; i++) lq.push_back(10);
    run_plan(1'b0, 0);
    check("count_wrapped", int'(frame_count_o), 0);

`ifdef MFCC_SEQ_WATCHDOG_EN
    mon_en = 1'b0;
    drive_to_mel();
    ms = cyc;
    check("wdt_mel_start", int'(mel_start_o), 1);
    seen = 1'b0; mv_at = 0; fd_at = 1'b0; to_at = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!seen) begin
        step(1);
        if (start_move_o) begin
          seen = 1'b1; mv_at = cyc; fd_at = frame_done_o; to_at = timeout_o;
        end
      end
    end
    check("wdt_move_seen", int'(seen), 1);
    check("wdt_move_delay", mv_at - ms, WDT);
    check("wdt_no_frame_done", int'(fd_at), 0);
    check("wdt_timeout_set", int'(to_at), 1);
    step(1);
    check("wdt_count_held", int'(frame_count_o), int'(exp_cnt));
    check("wdt_timeout_sticky", int'(timeout_o), 1);
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    check("wdt_timeout_cleared", int'(timeout_o), 0);
    mon_en = 1'b1;
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
